nonce_tx_scheduler: RTL and testbench

Shares the hub's single upstream UART transmitter between NUM_SLAVES slave nonce receivers. Each receiver delivers a 32-bit nonce with a one-cycle new_nonce pulse. This block holds one pending nonce per slave and grants the transmitter round-robin. It then serializes the granted nonce as 4 bytes, MSB first, to the host. It sits between the per-slave receive buffers and the hub's uart transmitter instance.

---
 rtl/nonce_hub_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 63 ++++++
 rtl/nonce_tx_scheduler.sv | 149 ++++++++++++++
 tb/tb_nonce_tx_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_hub_pkg.sv
// Shared definitions for the hub nonce path.
// Contents:
//   state_t     : serializer FSM states
//   NONCE_BYTES : bytes per nonce (4)
//   BYTE_W      : bits per UART byte (8)
//   NONCE_W     : bits per nonce (32)
//   clog2()     : ceiling log2, never below 1, used to size index/pointer fields
package nonce_hub_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        ACK   = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam int NONCE_BYTES = 4;
    localparam int BYTE_W      = 8;
    localparam int NONCE_W     = NONCE_BYTES * BYTE_W;

    // A one-entry pointer still needs one bit, so the result is clamped to 1.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// The search starts at the priority pointer and wraps modulo N. The pointer
// moves to one past the winner whenever the grant is taken.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   advance    : the current grant is consumed this cycle; move the pointer
//   grant      : one-hot grant (combinational)
//   grant_idx  : binary index of the grant (combinational)
//   grant_any  : at least one request is present
module rr_arbiter
    import nonce_hub_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    logic             found;

    assign grant_any = |req;

    // Candidates are visited in the order ptr, ptr+1, ... N is not
    // necessarily a power of two, so the wrap is an explicit subtract.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            cand = sum[PTR_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && grant_any) begin
            ptr_q <= (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/nonce_tx_scheduler.sv
// Shares the hub's single upstream UART transmitter between NUM_SLAVES
// nonce receivers. Each slave has one pending slot, and a newer nonce
// replaces an unsent one. Slots are granted round-robin. The granted nonce
// is sent as 4 bytes, most significant byte first.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   slave_nonce     : 32 bits per slave, slave i on [32i+31:32i]
//   slave_new_nonce : one-cycle capture strobe per slave
//   tx_busy         : transmitter busy
//   tx_start        : one-cycle transmit strobe for tx_data
//   tx_data         : byte being transmitted
//   pending         : slot i holds an untransmitted nonce
//   overflow        : one-cycle pulse, slot i was overwritten before it was sent
//   active_slave    : slave being serialized (meaningful while busy_o)
//   busy_o          : a nonce is being serialized
//
// Transmitter handshake: tx_start pulses only from LOAD with tx_busy low.
// The transmitter raises tx_busy within one cycle after tx_start. ACK
// absorbs that latency, and DRAIN then waits for tx_busy to fall.
// tx_data is written only in LOAD, so it holds from tx_start until busy drops.
module nonce_tx_scheduler
    import nonce_hub_pkg::*;
#(
    parameter int NUM_SLAVES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [32*NUM_SLAVES-1:0] slave_nonce,
    input  logic [NUM_SLAVES-1:0]    slave_new_nonce,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic [NUM_SLAVES-1:0]    pending,
    output logic [NUM_SLAVES-1:0]    overflow,
    output logic [3:0]               active_slave,
    output logic                     busy_o
);

    localparam int PTR_W = clog2(NUM_SLAVES);

    logic [NONCE_W-1:0]    slot_q [NUM_SLAVES];
    logic [NUM_SLAVES-1:0] pending_q;
    logic [NUM_SLAVES-1:0] overflow_q;

    state_t                state_q;
    logic [NONCE_W-1:0]    shift_q;
    logic [1:0]            cnt_q;

    logic [NUM_SLAVES-1:0] grant_oh;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic                  grant_fire;

    assign grant_fire = (state_q == IDLE) && grant_any;
    assign pending    = pending_q;
    assign overflow   = overflow_q;

    rr_arbiter #(
        .N     (NUM_SLAVES),
        .PTR_W (PTR_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (pending_q),
        .advance   (grant_fire),
        .grant     (grant_oh),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Slot storage. A capture on the grant edge of the same slot is not an
    // overflow: the grant has already taken the old contents, so the new
    // nonce becomes a fresh pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                slot_q[i] <= '0;
            end
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                overflow_q[i] <= slave_new_nonce[i] & pending_q[i]
                                 & ~(grant_fire & grant_oh[i]);
                if (slave_new_nonce[i]) begin
                    slot_q[i]    <= slave_nonce[32*i +: 32];
                    pending_q[i] <= 1'b1;
                end else if (grant_fire && grant_oh[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    // Serializer FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            active_slave <= '0;
            busy_o       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        shift_q      <= slot_q[grant_idx];
                        active_slave <= 4'(grant_idx);
                        busy_o       <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= LOAD;
                    end
                end
                LOAD: begin
                    tx_data <= shift_q[NONCE_W-1 -: BYTE_W];
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    state_q  <= ACK;
                end
                ACK: begin
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        shift_q <= {shift_q[NONCE_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            busy_o  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_tx_scheduler.sv
// Directed bench for nonce_tx_scheduler (NUM_SLAVES = 4).
// A small transmitter model answers tx_start with a busy window of
// programmable latency and length. Every byte it accepts is compared against
// the expected byte/slave queues.
module tb_nonce_tx_scheduler;

  localparam int NS = 4;

  logic             clk;
  logic             rst_n;
  logic [32*NS-1:0] slave_nonce;
  logic [NS-1:0]    slave_new_nonce;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [NS-1:0]    pending;
  logic [NS-1:0]    overflow;
  logic [3:0]       active_slave;
  logic             busy_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         exp_slave_q[$];

  int busy_lat = 0;
  int busy_len = 10;

  nonce_tx_scheduler #(.NUM_SLAVES(NS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .slave_nonce     (slave_nonce),
    .slave_new_nonce (slave_new_nonce),
    .tx_busy         (tx_busy),
    .tx_start        (tx_start),
    .tx_data         (tx_data),
    .pending         (pending),
    .overflow        (overflow),
    .active_slave    (active_slave),
    .busy_o          (busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input bit ok,
                     input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // transmitter model and byte scoreboard
  initial begin : tx_model
    logic [7:0] cur_b;
    logic [7:0] eb;
    int         es;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        cur_b = tx_data;
        chk("start_while_busy", tx_busy === 1'b0, tx_busy, 1'b0);
        chk("unexpected_start", (exp_q.size() != 0) === 1'b1, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          eb = exp_q.pop_front();
          es = exp_slave_q.pop_front();
          chk("tx_data", cur_b === eb, cur_b, eb);
          chk("active_slave_at_start", active_slave === 4'(es), active_slave, 4'(es));
        end
        repeat (busy_lat) @(posedge clk);
        @(posedge clk); #1;
        tx_busy = 1'b1;
        repeat (busy_len - 1) begin
          @(posedge clk); #1;
          if (rst_n) begin
            chk("tx_data_hold", tx_data === cur_b, tx_data, cur_b);
            chk("start_during_busy", tx_start === 1'b0, tx_start, 1'b0);
          end
        end
        @(posedge clk); #1;
        tx_busy = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic drive(input int s, input logic [31:0] d);
    slave_nonce[32*s +: 32] = d;
    slave_new_nonce[s]      = 1'b1;
  endtask

  // Advances to the capture edge; returns #1 after it with strobes cleared.
  task automatic edge_clear();
    @(posedge clk); #1;
    slave_new_nonce = '0;
    slave_nonce     = '0;
  endtask

  task automatic push_exp(input int s, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(d[31-8*b -: 8]);
      exp_slave_q.push_back(s);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pending"}, pending === 4'b0000, pending, 4'b0000);
    chk({tag, "_overflow"}, overflow === 4'b0000, overflow, 4'b0000);
    chk({tag, "_tx_start"}, tx_start === 1'b0, tx_start, 1'b0);
    chk({tag, "_tx_data"}, tx_data === 8'h00, tx_data, 8'h00);
    chk({tag, "_active_slave"}, active_slave === 4'h0, active_slave, 4'h0);
    chk({tag, "_busy_o"}, busy_o === 1'b0, busy_o, 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy_o !== 1'b0) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_remaining_bytes"}, exp_q.size() === 0, exp_q.size(), 0);
    chk({tag, "_idle_busy_o"}, busy_o === 1'b0, busy_o, 1'b0);
    chk({tag, "_idle_pending"}, pending === 4'b0000, pending, 4'b0000);
  endtask

  // directed sequence
  initial begin
    int k;
    rst_n           = 1'b0;
    slave_nonce     = '0;
    slave_new_nonce = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single nonce, slave 2: latency and byte order
    push_exp(2, 32'hDEADBEEF);
    @(negedge clk);
    drive(2, 32'hDEADBEEF);
    edge_clear();
    chk("single_pending_after_capture", pending === 4'b0100, pending, 4'b0100);
    chk("single_busy_before_grant", busy_o === 1'b0, busy_o, 1'b0);
    @(posedge clk); #1;
    chk("single_pending_cleared_at_grant", pending === 4'b0000, pending, 4'b0000);
    chk("single_busy_at_grant", busy_o === 1'b1, busy_o, 1'b1);
    chk("single_active_slave", active_slave === 4'd2, active_slave, 4'd2);
    chk("single_no_start_in_load", tx_start === 1'b0, tx_start, 1'b0);
    @(posedge clk); #1;
    chk("single_first_start_latency", tx_start === 1'b1, tx_start, 1'b1);
    wait_done("single");

    // round robin from ptr=0, then slave 1 again after the last grant
    reset_dut();
    for (int s = 0; s < NS; s++) push_exp(s, 32'h11111111 * (s + 1));
    @(negedge clk);
    for (int s = 0; s < NS; s++) drive(s, 32'h11111111 * (s + 1));
    edge_clear();
    chk("rr_all_pending", pending === 4'b1111, pending, 4'b1111);
    k = 0;
    while (!(busy_o === 1'b1 && active_slave === 4'd3) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("rr_slave3_granted", active_slave === 4'd3, active_slave, 4'd3);
    push_exp(1, 32'h55555555);
    drive(1, 32'h55555555);
    edge_clear();
    chk("rr_repeat_pending", pending === 4'b0010, pending, 4'b0010);
    wait_done("rr");

    // overflow on slave 0 while slave 3 transmits
    push_exp(3, 32'h0A0B0C0D);
    push_exp(0, 32'hBBBBBBBB);
    @(negedge clk);
    drive(3, 32'h0A0B0C0D);
    edge_clear();
    repeat (3) @(posedge clk);
    #1;
    drive(0, 32'hAAAAAAAA);
    edge_clear();
    chk("ovf_first_capture_no_overflow", overflow === 4'b0000, overflow, 4'b0000);
    chk("ovf_first_capture_pending", pending === 4'b0001, pending, 4'b0001);
    repeat (5) @(posedge clk);
    #1;
    drive(0, 32'hBBBBBBBB);
    edge_clear();
    chk("ovf_pulse", overflow === 4'b0001, overflow, 4'b0001);
    chk("ovf_pending_kept", pending === 4'b0001, pending, 4'b0001);
    @(posedge clk); #1;
    chk("ovf_pulse_one_cycle", overflow === 4'b0000, overflow, 4'b0000);
    wait_done("ovf");

    // capture on the grant edge of the same slot
    push_exp(1, 32'h12345678);
    push_exp(1, 32'h9ABCDEF0);
    @(negedge clk);
    drive(1, 32'h12345678);
    edge_clear();
    chk("coll_pending", pending === 4'b0010, pending, 4'b0010);
    drive(1, 32'h9ABCDEF0);
    edge_clear();
    chk("coll_granted", busy_o === 1'b1, busy_o, 1'b1);
    chk("coll_active_slave", active_slave === 4'd1, active_slave, 4'd1);
    chk("coll_new_pending", pending === 4'b0010, pending, 4'b0010);
    chk("coll_no_overflow", overflow === 4'b0000, overflow, 4'b0000);
    @(posedge clk); #1;
    chk("coll_no_overflow_later", overflow === 4'b0000, overflow, 4'b0000);
    wait_done("coll");

    // late busy rise and long busy
    busy_lat = 1;
    busy_len = 13;
    push_exp(2, 32'hC0FFEE00);
    @(negedge clk);
    drive(2, 32'hC0FFEE00);
    edge_clear();
    wait_done("hs");
    busy_lat = 0;
    busy_len = 10;

    // reset in the gap after the second byte
    push_exp(0, 32'h01020304);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_slave_q.pop_back());
    void'(exp_slave_q.pop_back());
    @(negedge clk);
    drive(0, 32'h01020304);
    edge_clear();
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin @(negedge clk); k++; end
    k = 0;
    while (tx_busy !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (tx_busy !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    chk("rst_two_bytes_sent", exp_q.size() === 0, exp_q.size(), 0);
    chk("rst_still_busy_before_reset", busy_o === 1'b1, busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("rst_no_resume_busy", busy_o === 1'b0, busy_o, 1'b0);
    chk("rst_no_resume_pending", pending === 4'b0000, pending, 4'b0000);
    chk("rst_no_extra_bytes", exp_q.size() === 0, exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
